// File: rtl/shift_arbiter.sv
// Round-robin arbiter in front of the shared 32-bit log shifter, with one registered result slot.
// Optional arithmetic right shift is enabled by defining SHIFT_ARBITER_SRA_EN.
module shift_arbiter #(
  parameter int unsigned RESET_PRIORITY = 0
) (
  input  logic        clock,
  input  logic        resetn,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_data,
  input  logic [4:0]  req0_shamt,
  input  logic        req0_op,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_data,
  input  logic [4:0]  req1_shamt,
  input  logic        req1_op,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_id,

  output logic [15:0] acc0_cnt,
  output logic [15:0] acc1_cnt
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e      state_q, state_d;
  logic        prio_q, prio_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_id_q, rsp_id_d;
  logic [15:0] acc0_cnt_q, acc0_cnt_d;
  logic [15:0] acc1_cnt_q, acc1_cnt_d;

  logic        can_accept;
  logic        grant;
  logic        accept;

  logic [31:0] sel_data;
  logic [4:0]  sel_shamt;
  logic        sel_op;
  logic [31:0] shift_in;
  logic [31:0] shift_out;
  logic        fill;
  logic [5:0][31:0] stage;

  // ---------------------------------------------------------------------------
  // Arbitration and handshakes
  // ---------------------------------------------------------------------------
  always_comb begin
    can_accept = (state_q == StEmpty) | rsp_ready;

    grant = prio_q;
    if (req0_valid && !req1_valid) begin
      grant = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant = 1'b1;
    end

    // resetn gates the readies so nothing is accepted while reset is held
    accept     = (req0_valid | req1_valid) & can_accept & resetn;
    req0_ready = accept & ~grant & req0_valid;
    req1_ready = accept &  grant & req1_valid;
  end

  // ---------------------------------------------------------------------------
  // Shared shifter
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_data  = grant ? req1_data  : req0_data;
    sel_shamt = grant ? req1_shamt : req0_shamt;
    sel_op    = grant ? req1_op    : req0_op;
  end

`ifdef SHIFT_ARBITER_SRA_EN
  function automatic logic [31:0] bit_reverse(input logic [31:0] x);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[i] = x[31 - i];
    end
    return r;
  endfunction

  // Right shift reuses the left shifter on the mirrored operand; fill carries the sign.
  always_comb begin
    fill     = sel_op & sel_data[31];
    shift_in = sel_op ? bit_reverse(sel_data) : sel_data;
  end
`else
  logic unused_op;

  always_comb begin
    unused_op = sel_op;
    fill      = 1'b0;
    shift_in  = sel_data;
  end
`endif

  always_comb begin
    stage[0] = shift_in;
    for (int k = 0; k < 5; k++) begin
      if (sel_shamt[k]) begin
        stage[k+1] = (stage[k] << (1 << k)) | ({32{fill}} & ~(32'hFFFF_FFFF << (1 << k)));
      end else begin
        stage[k+1] = stage[k];
      end
    end
  end

`ifdef SHIFT_ARBITER_SRA_EN
  always_comb begin
    shift_out = sel_op ? bit_reverse(stage[5]) : stage[5];
  end
`else
  always_comb begin
    shift_out = stage[5];
  end
`endif

  // ---------------------------------------------------------------------------
  // Slot FSM, priority and counters
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    acc0_cnt_d = acc0_cnt_q;
    acc1_cnt_d = acc1_cnt_q;

    unique case (state_q)
      StEmpty: begin
        if (accept) state_d = StFull;
      end
      StFull: begin
        if (rsp_ready && !accept) state_d = StEmpty;
      end
      default: state_d = StEmpty;
    endcase

    if (accept) begin
      prio_d     = ~grant;
      rsp_data_d = shift_out;
      rsp_id_d   = grant;
    end

    if (req0_ready && req0_valid && (acc0_cnt_q != 16'hFFFF)) begin
      acc0_cnt_d = acc0_cnt_q + 16'd1;
    end
    if (req1_ready && req1_valid && (acc1_cnt_q != 16'hFFFF)) begin
      acc1_cnt_d = acc1_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StEmpty;
      prio_q     <= 1'(RESET_PRIORITY);
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
      acc0_cnt_q <= '0;
      acc1_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      acc0_cnt_q <= acc0_cnt_d;
      acc1_cnt_q <= acc1_cnt_d;
    end
  end

  assign rsp_valid = (state_q == StFull);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign acc0_cnt  = acc0_cnt_q;
  assign acc1_cnt  = acc1_cnt_q;

endmodule
